// File: rtl/mbtrain_pkg.sv
// Shared types and constants for the MBTRAIN step sequencer.
package mbtrain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_RUN,
    ST_RELEASE,
    ST_DONE,
    ST_ERROR
  } state_t;

  // Decoded sideband message codes exchanged by the step sub-FSMs
  localparam logic [3:0] SB_START_REQ  = 4'b0001;
  localparam logic [3:0] SB_START_RESP = 4'b0010;
  localparam logic [3:0] SB_END_REQ    = 4'b0011;
  localparam logic [3:0] SB_END_RESP   = 4'b0100;

  localparam int DEFAULT_TIMEOUT_CYCLES = 8000;

endpackage

// File: rtl/mbtrain_step_timer.sv
// Per-step watchdog: cleared on step entry, counts while enabled,
// flags expiry once TIMEOUT_CYCLES-1 cycles have elapsed.
module mbtrain_step_timer #(
  parameter int TIMEOUT_CYCLES = 8000,
  parameter int TO_CNT_W       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);

  logic [TO_CNT_W-1:0] count;

  // Count register: clear has priority over counting
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + TO_CNT_W'(1);
    end
  end

  assign expire = (count == TO_CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mbtrain_step_sequencer.sv
// Runs the MBTRAIN step sub-FSMs one at a time with a handshake on
// enable/ack, owns the sideband TX slot and watches each step for timeout.
module mbtrain_step_sequencer
  import mbtrain_pkg::*;
#(
  parameter int NUM_STEPS      = 4,
  parameter int MSG_W          = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int TO_CNT_W       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_start,
  input  logic [NUM_STEPS-1:0]           i_step_mask,
  input  logic [NUM_STEPS-1:0]           i_step_ack,
  input  logic [NUM_STEPS*MSG_W-1:0]     i_step_msg,
  input  logic [NUM_STEPS-1:0]           i_step_valid,
  output logic [NUM_STEPS-1:0]           o_step_en,
  output logic [MSG_W-1:0]               o_sb_msg,
  output logic                           o_sb_valid,
  output logic [$clog2(NUM_STEPS+1)-1:0] o_cur_step,
  output logic                           o_done,
  output logic                           o_timeout
);

  localparam int IDX_W = $clog2(NUM_STEPS + 1);

  state_t               state, state_next;
  logic [IDX_W-1:0]     idx, idx_next;
  logic [NUM_STEPS-1:0] mask_q, mask_next;
  logic [NUM_STEPS-1:0] en_next;
  logic [MSG_W-1:0]     sb_msg_next;
  logic                 sb_valid_next;
  logic                 done_next;
  logic                 timeout_next;

  logic                 timer_clear;
  logic                 timer_en;
  logic                 timer_expire;

  logic                 cur_mask;
  logic                 cur_ack;
  logic                 cur_valid;
  logic [MSG_W-1:0]     cur_msg;
  logic [NUM_STEPS-1:0] sel_onehot;
  logic                 at_end;

  mbtrain_step_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_CNT_W       (TO_CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .en     (timer_en),
    .expire (timer_expire)
  );

  // Pick out the current step's mask/ack/valid/msg; everything else is ignored
  always_comb begin
    cur_mask   = 1'b0;
    cur_ack    = 1'b0;
    cur_valid  = 1'b0;
    cur_msg    = '0;
    sel_onehot = '0;
    for (int k = 0; k < NUM_STEPS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_mask      = mask_q[k];
        cur_ack       = i_step_ack[k];
        cur_valid     = i_step_valid[k];
        cur_msg       = i_step_msg[k*MSG_W +: MSG_W];
        sel_onehot[k] = 1'b1;
      end
    end
    at_end = (idx == IDX_W'(NUM_STEPS));
  end

  // Next-state and next-output logic; abort beats ack, ack beats timeout
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    mask_next     = mask_q;
    en_next       = '0;
    timer_clear   = 1'b0;
    timer_en      = 1'b0;
    sb_msg_next   = '0;
    sb_valid_next = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_next = ST_SELECT;
          mask_next  = i_step_mask;
          idx_next   = '0;
        end
      end
      ST_SELECT: begin
        if (!i_start) begin
          state_next = ST_IDLE;
        end else if (at_end) begin
          state_next = ST_DONE;
        end else if (!cur_mask) begin
          idx_next = idx + IDX_W'(1);
        end else begin
          state_next  = ST_RUN;
          en_next     = sel_onehot;
          timer_clear = 1'b1;
        end
      end
      ST_RUN: begin
        if (!i_start) begin
          state_next = ST_IDLE;
        end else if (cur_ack) begin
          state_next = ST_RELEASE;
        end else if (timer_expire) begin
          state_next = ST_ERROR;
        end else begin
          en_next  = sel_onehot;
          timer_en = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!i_start) begin
          state_next = ST_IDLE;
        end else if (!cur_ack) begin
          state_next = ST_SELECT;
          idx_next   = idx + IDX_W'(1);
        end else if (timer_expire) begin
          state_next = ST_ERROR;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_DONE: begin
        if (!i_start) state_next = ST_IDLE;
      end
      ST_ERROR: begin
        if (!i_start) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if ((state == ST_RUN || state == ST_RELEASE) && i_start) begin
      sb_msg_next   = cur_msg;
      sb_valid_next = cur_valid;
    end

    done_next    = (state_next == ST_DONE);
    timeout_next = (state_next == ST_ERROR);
  end

  // State, index, latched mask and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      mask_q     <= '0;
      o_step_en  <= '0;
      o_sb_msg   <= '0;
      o_sb_valid <= 1'b0;
      o_cur_step <= '0;
      o_done     <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      mask_q     <= mask_next;
      o_step_en  <= en_next;
      o_sb_msg   <= sb_msg_next;
      o_sb_valid <= sb_valid_next;
      o_cur_step <= idx_next;
      o_done     <= done_next;
      o_timeout  <= timeout_next;
    end
  end

endmodule

// File: tb/tb_mbtrain_step_sequencer.sv
// Self-checking bench for mbtrain_step_sequencer: a table of whole-run
// scenarios plus hand-written sequences for sideband, timeout, abort, reset.
module tb_mbtrain_step_sequencer;

  localparam int NS    = 4;
  localparam int MW    = 4;
  localparam int TO    = 20;
  localparam int IDX_W = $clog2(NS + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              i_start;
  logic [NS-1:0]     i_step_mask;
  logic [NS-1:0]     i_step_ack;
  logic [NS*MW-1:0]  i_step_msg;
  logic [NS-1:0]     i_step_valid;
  logic [NS-1:0]     o_step_en;
  logic [MW-1:0]     o_sb_msg;
  logic              o_sb_valid;
  logic [IDX_W-1:0]  o_cur_step;
  logic              o_done;
  logic              o_timeout;

  mbtrain_step_sequencer #(
    .NUM_STEPS      (NS),
    .MSG_W          (MW),
    .TIMEOUT_CYCLES (TO),
    .TO_CNT_W       (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_step_mask  (i_step_mask),
    .i_step_ack   (i_step_ack),
    .i_step_msg   (i_step_msg),
    .i_step_valid (i_step_valid),
    .o_step_en    (o_step_en),
    .o_sb_msg     (o_sb_msg),
    .o_sb_valid   (o_sb_valid),
    .o_cur_step   (o_cur_step),
    .o_done       (o_done),
    .o_timeout    (o_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NS-1:0]    mask;
    logic [NS-1:0]    hang;
    logic [15:0]      order;
    int               n_order;
    logic             exp_done;
    logic             exp_to;
    logic [IDX_W-1:0] exp_cur;
  } vec_t;

  int n_compared = 0;
  int n_mismatch = 0;
  int cyc = 0;

  logic [NS-1:0] hang;
  logic [NS-1:0] en_q [$];
  logic [MW:0]   sb_q [$];
  logic [NS-1:0] prev_en = '0;
  int            run_cnt [NS];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Step model: ack 5 cycles after enable rises unless hung, drop ack once enable falls
  always @(negedge clk) begin
    if (rst) begin
      i_step_ack = '0;
      for (int k = 0; k < NS; k++) run_cnt[k] = 0;
    end else begin
      for (int k = 0; k < NS; k++) begin
        if (o_step_en[k]) begin
          run_cnt[k]++;
          if (!hang[k] && run_cnt[k] >= 5) i_step_ack[k] = 1'b1;
        end else begin
          run_cnt[k] = 0;
          i_step_ack[k] = 1'b0;
        end
      end
    end
  end

  // Enable monitor: one-hot check and in-order pop of expected enable patterns
  always @(negedge clk) begin
    if (rst) begin
      prev_en = '0;
    end else if (o_step_en !== prev_en) begin
      checkOutput("en_onehot", ($countones(o_step_en) <= 1) ? 32'd1 : 32'd0, 32'd1);
      if (o_step_en != '0) begin
        if (en_q.size() == 0) checkOutput("en_unexpected", 32'(o_step_en), 32'd0);
        else checkOutput("en_order", 32'(o_step_en), 32'(en_q.pop_front()));
      end
      prev_en = o_step_en;
    end
  end

  task automatic checkSb(input string name);
    logic [MW:0] e;
    e = sb_q.pop_front();
    checkOutput({name, "_valid"}, 32'(o_sb_valid), 32'(e[MW]));
    checkOutput({name, "_msg"}, 32'(o_sb_msg), 32'(e[MW-1:0]));
  endtask

  task automatic waitEn(input logic [NS-1:0] pat, input string name);
    int c;
    c = 0;
    while (o_step_en !== pat && c < 200) begin
      @(negedge clk);
      c++;
    end
    checkOutput(name, 32'(o_step_en), 32'(pat));
  endtask

  task automatic applyStimulus(input vec_t v, input int id);
    int c;
    for (int k = 0; k < v.n_order; k++) en_q.push_back(v.order[4*k +: 4]);
    hang        = v.hang;
    i_step_mask = v.mask;
    i_start     = 1'b1;
    c = 0;
    while (!(o_done || o_timeout) && c < 300) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    $display("[TB] scenario %0d mask=%b hang=%b", id, v.mask, v.hang);
    checkOutput("vec_done", 32'(o_done), 32'(v.exp_done));
    checkOutput("vec_timeout", 32'(o_timeout), 32'(v.exp_to));
    checkOutput("vec_cur_step", 32'(o_cur_step), 32'(v.exp_cur));
    checkOutput("vec_en_idle", 32'(o_step_en), 32'd0);
    checkOutput("vec_en_left", 32'(en_q.size()), 32'd0);
    en_q.delete();
    i_start = 1'b0;
    @(negedge clk);
    checkOutput("vec_done_clr", 32'(o_done), 32'd0);
    checkOutput("vec_to_clr", 32'(o_timeout), 32'd0);
    hang = '0;
    @(negedge clk);
  endtask

  vec_t vecs [6];

  initial begin
    int t0;
    int c;

    vecs[0] = '{mask: 4'b1111, hang: 4'b0000, order: 16'h8421, n_order: 4, exp_done: 1'b1, exp_to: 1'b0, exp_cur: 3'd4};
    vecs[1] = '{mask: 4'b0101, hang: 4'b0000, order: 16'h0041, n_order: 2, exp_done: 1'b1, exp_to: 1'b0, exp_cur: 3'd4};
    vecs[2] = '{mask: 4'b0000, hang: 4'b0000, order: 16'h0000, n_order: 0, exp_done: 1'b1, exp_to: 1'b0, exp_cur: 3'd4};
    vecs[3] = '{mask: 4'b1111, hang: 4'b0010, order: 16'h0021, n_order: 2, exp_done: 1'b0, exp_to: 1'b1, exp_cur: 3'd1};
    vecs[4] = '{mask: 4'b1010, hang: 4'b0000, order: 16'h0082, n_order: 2, exp_done: 1'b1, exp_to: 1'b0, exp_cur: 3'd4};
    vecs[5] = '{mask: 4'b1101, hang: 4'b1000, order: 16'h0841, n_order: 3, exp_done: 1'b0, exp_to: 1'b1, exp_cur: 3'd3};

    rst = 1'b1;
    i_start = 1'b0;
    i_step_mask = '0;
    i_step_msg = '0;
    i_step_valid = '0;
    hang = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_en", 32'(o_step_en), 32'd0);
    checkOutput("rst_sb_msg", 32'(o_sb_msg), 32'd0);
    checkOutput("rst_sb_valid", 32'(o_sb_valid), 32'd0);
    checkOutput("rst_cur_step", 32'(o_cur_step), 32'd0);
    checkOutput("rst_done", 32'(o_done), 32'd0);
    checkOutput("rst_timeout", 32'(o_timeout), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Sideband mux: only step 2 traffic may appear while step 0 also talks
    $display("[TB] sideband mux sequence");
    hang = 4'b0100;
    i_step_valid = 4'b0101;
    i_step_msg = {4'h0, 4'h3, 4'h0, 4'h1};
    en_q.push_back(4'b0100);
    i_step_mask = 4'b0100;
    i_start = 1'b1;
    waitEn(4'b0100, "sb_en_reached");
    sb_q.push_back({1'b0, 4'h0});
    checkSb("sb_select");
    sb_q.push_back({1'b1, 4'h3});
    @(negedge clk);
    checkSb("sb_first");
    i_step_msg = {4'h0, 4'h4, 4'h0, 4'h2};
    sb_q.push_back({1'b1, 4'h4});
    @(negedge clk);
    checkSb("sb_change");
    i_step_valid = 4'b0001;
    sb_q.push_back({1'b0, 4'h4});
    @(negedge clk);
    checkSb("sb_step0_only");
    i_start = 1'b0;
    sb_q.push_back({1'b0, 4'h0});
    @(negedge clk);
    checkSb("sb_abort");
    checkOutput("sb_abort_en", 32'(o_step_en), 32'd0);
    checkOutput("sb_abort_to", 32'(o_timeout), 32'd0);
    i_step_valid = '0;
    i_step_msg = '0;
    hang = '0;
    @(negedge clk);

    // Timeout lands exactly TO cycles after RUN entry
    $display("[TB] timeout sequence");
    hang = 4'b0010;
    en_q.push_back(4'b0010);
    i_step_mask = 4'b0010;
    i_start = 1'b1;
    waitEn(4'b0010, "to_en_reached");
    t0 = cyc;
    c = 0;
    while (!o_timeout && c < 100) begin
      @(negedge clk);
      c++;
    end
    checkOutput("to_latency", 32'(cyc - t0), 32'(TO));
    checkOutput("to_flag", 32'(o_timeout), 32'd1);
    checkOutput("to_en_off", 32'(o_step_en), 32'd0);
    checkOutput("to_no_done", 32'(o_done), 32'd0);
    i_start = 1'b0;
    repeat (2) @(negedge clk);
    hang = '0;

    // Abort during step 1; the following table run must restart at step 0
    $display("[TB] abort sequence");
    en_q.push_back(4'b0001);
    en_q.push_back(4'b0010);
    i_step_mask = 4'b1111;
    i_start = 1'b1;
    waitEn(4'b0010, "abort_en_reached");
    i_start = 1'b0;
    @(negedge clk);
    checkOutput("abort_en", 32'(o_step_en), 32'd0);
    checkOutput("abort_sb_valid", 32'(o_sb_valid), 32'd0);
    checkOutput("abort_done", 32'(o_done), 32'd0);
    checkOutput("abort_en_left", 32'(en_q.size()), 32'd0);
    en_q.delete();
    @(negedge clk);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

    // Reset while a step is running clears every output
    $display("[TB] reset mid-run sequence");
    i_step_valid = 4'b0001;
    i_step_msg = {4'h0, 4'h0, 4'h0, 4'h1};
    en_q.push_back(4'b0001);
    i_step_mask = 4'b0001;
    i_start = 1'b1;
    waitEn(4'b0001, "rstrun_en_reached");
    sb_q.push_back({1'b1, 4'h1});
    @(negedge clk);
    checkSb("rstrun_sb");
    rst = 1'b1;
    i_start = 1'b0;
    @(negedge clk);
    checkOutput("rstrun_en", 32'(o_step_en), 32'd0);
    checkOutput("rstrun_sb_valid", 32'(o_sb_valid), 32'd0);
    checkOutput("rstrun_sb_msg", 32'(o_sb_msg), 32'd0);
    checkOutput("rstrun_cur", 32'(o_cur_step), 32'd0);
    checkOutput("rstrun_done", 32'(o_done), 32'd0);
    rst = 1'b0;
    i_step_valid = '0;
    i_step_msg = '0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
